serial_mult_scheduler: RTL
==========================

// Module: serial_mult_scheduler
// PURPOSE
//  Shares one bit-serial multiply datapath between two requesters. Interface: clk, reset.
//  Protocol: load_b/B parallel load, start_a/A serial input, start_c/c serial output.
//  Round-robin arbitration; captures the winner's operands, sequences load -> stream -> drain.
//  Deserializes the result and returns it tagged with the requester id. Sits between the
//  bus-side requesters and the serial multiplier core.
// PARAMETERS
//  AW       8    width of serial operand A (bits, sent LSB first)
//  BW       4    width of parallel operand B
//  RW       12   result width collected from c (AW+BW)
//  TIMEOUT  16   max cycles in DRAIN without a valid c bit before error
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-low; clears all state and outputs
//  req         in   2   request per requester; held high until ack
//  a0, a1      in   AW  operand A of requester 0/1; sampled on ack
//  b0, b1      in   BW  operand B of requester 0/1; sampled on ack
//  ack         out  2   one-cycle pulse: request accepted, operands captured
//  done        out  1   one-cycle pulse: result/err valid
//  done_id     out  1   requester that owns the completed op
//  result      out  RW  assembled product, held until next done
//  err         out  1   valid with done; 1 = timeout or short result stream
//  busy        out  1   high in any state other than IDLE
//  dp_load_b   out  1   to datapath load_b
//  dp_B        out  BW  to datapath B
//  dp_start_a  out  1   to datapath start_a (A bits valid)
//  dp_A        out  1   to datapath A
//  dp_start_c  in   1   from datapath start_c (c bit valid)
//  dp_c        in   1   from datapath c
// BEHAVIOUR
//  Reset (reset=0): all outputs 0, state IDLE, rr pointer=0 (req0 preferred), counters 0.
//  Reset takes effect immediately, also mid-operation: datapath strobes drop asynchronously.
//  In-flight op is discarded; no done is issued.
//  States: IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
//  IDLE: any req set -> grant g.
//   - Both requesting: g = rr pointer. Otherwise g = the single requester.
//   - ack[g]=1 for this cycle only; a_g/b_g and g are registered at the edge; go to LOAD.
//  LOAD (1 cycle): dp_load_b=1, dp_B=captured b. All other dp outputs 0.
//  STREAM (AW cycles, k=0..AW-1): dp_start_a=1, dp_A=a_reg[k]. dp_B stays driven.
//  DRAIN: dp_start_a=0, dp_A=0.
//  Capture: enabled in STREAM and DRAIN.
//   - Each cycle with dp_start_c=1 shifts dp_c into result (LSB-first, shift right into MSB).
//   - Each such cycle increments bitcnt.
//   - bitcnt==RW -> DONE. Further start_c bits in that cycle or later are ignored.
//  Errors (both -> DONE with err=1; result holds the partial shift value):
//   - start_c falls after >=1 bit but before RW bits.
//   - DRAIN runs TIMEOUT consecutive cycles with start_c=0 and bitcnt==0.
//  DONE (1 cycle): done=1, done_id=g, err as set. rr pointer := ~g. Next state IDLE.
//  Back-to-back ops: a req seen in IDLE immediately after DONE is accepted, so there is
//  one IDLE cycle between ops.
//  req in non-IDLE states is ignored; no ack. req dropped before ack: nothing queued.
//  Min latency, ack to done: 1+AW+RW-ish, set by the datapath.
//  Drain counter: DRAIN ends exactly when the RW-th bit is seen; bitcnt width = clog2(RW+1).
// TESTING
//  1. req0, a0=8'h0B, b0=4'h6, behavioural serial multiplier model:
//     -> ack=2'b01 once; done, done_id=0, result=12'h042, err=0.
//  2. Datapath strobes for test 1:
//     -> dp_load_b high exactly 1 cycle with dp_B=4'h6.
//     -> dp_start_a high exactly 8 cycles with dp_A = 1,1,0,1,0,0,0,0.
//  3. req=2'b11 continuously with distinct operands:
//     -> grants alternate 0,1,0,1; each done_id matches its operands' product; busy never
//        drops between ops except one IDLE cycle.
//  4. Model never raises start_c -> TIMEOUT(16) cycles after DRAIN entry: done=1, err=1,
//     then IDLE, busy=0.
//  5. Model sends 5 c bits then drops start_c -> done=1, err=1 on the following cycle.
//  6. reset driven low mid-STREAM (k=3) -> all outputs 0 before the next clk edge, no done.
//     After release, new req1 completes correctly with rr favouring req0 first.

Source files
------------

// File: rtl/serial_mult_scheduler.sv
// Round-robin front end for one bit-serial multiplier: grant, load B, stream A, collect c, return tagged result.
// Latency ack->done is 1+AW+RW cycles with a prompt datapath; req is ignored (no ack) while busy.
module serial_mult_scheduler #(
  parameter int AW      = 8,
  parameter int BW      = 4,
  parameter int RW      = 12,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  input  logic [BW-1:0] b0,
  input  logic [BW-1:0] b1,
  output logic [1:0]    ack,
  output logic          done,
  output logic          done_id,
  output logic [RW-1:0] result,
  output logic          err,
  output logic          busy,
  output logic          dp_load_b,
  output logic [BW-1:0] dp_B,
  output logic          dp_start_a,
  output logic          dp_A,
  input  logic          dp_start_c,
  input  logic          dp_c
);

  localparam int CW = $clog2(RW + 1);
  localparam int KW = $clog2(AW + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  logic          r_rr;
  logic          r_g;
  logic          r_err;
  logic [AW-1:0] r_a;
  logic [BW-1:0] r_b;
  logic [RW-1:0] r_shift;
  logic [RW-1:0] r_result;
  logic [CW-1:0] r_bitcnt;
  logic [KW-1:0] r_k;
  logic [TW-1:0] r_tcnt;

  logic [1:0]    w_grant;
  logic          w_cap_en;
  logic          w_bit;
  logic          w_full;
  logic          w_short;
  logic          w_tmo;
  logic [RW-1:0] w_shift_nxt;

  always_comb begin
    w_grant = req;
    if (req == 2'b11) w_grant = r_rr ? 2'b10 : 2'b01;
  end

  // Capture runs in STREAM too, so a fast datapath may return bits before A is fully sent.
  assign w_cap_en    = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_bit       = w_cap_en && dp_start_c;
  assign w_shift_nxt = {dp_c, r_shift[RW-1:1]};
  assign w_full      = w_bit && (r_bitcnt == CW'(RW - 1));
  assign w_short     = w_cap_en && !dp_start_c && (r_bitcnt != '0);
  assign w_tmo       = (r_state == S_DRAIN) && !dp_start_c && (r_bitcnt == '0) &&
                       (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rr     <= 1'b0;
      r_g      <= 1'b0;
      r_err    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_shift  <= '0;
      r_result <= '0;
      r_bitcnt <= '0;
      r_k      <= '0;
      r_tcnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_g      <= w_grant[1];
            r_a      <= w_grant[1] ? a1 : a0;
            r_b      <= w_grant[1] ? b1 : b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_k      <= '0;
            r_tcnt   <= '0;
            r_err    <= 1'b0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_STREAM;
        S_STREAM, S_DRAIN: begin
          if (w_bit) begin
            r_shift  <= w_shift_nxt;
            r_bitcnt <= r_bitcnt + CW'(1);
          end
          if (w_full) begin
            r_result <= w_shift_nxt;
            r_err    <= 1'b0;
            r_state  <= S_DONE;
          end else if (w_short || w_tmo) begin
            r_result <= r_shift;
            r_err    <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_state == S_STREAM) begin
            r_a <= r_a >> 1;
            r_k <= r_k + KW'(1);
            if (r_k == KW'(AW - 1)) begin
              r_tcnt  <= '0;
              r_state <= S_DRAIN;
            end
          end else if (!dp_start_c && (r_bitcnt == '0)) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_DONE: begin
          r_rr    <= ~r_g;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ack is decided in the IDLE cycle itself; gating with reset keeps it low while held in reset.
  assign ack        = ((r_state == S_IDLE) && reset) ? w_grant : 2'b00;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign done_id    = done & r_g;
  assign err        = done & r_err;
  assign result     = r_result;
  assign dp_load_b  = (r_state == S_LOAD);
  assign dp_start_a = (r_state == S_STREAM);
  assign dp_A       = (r_state == S_STREAM) & r_a[0];
  assign dp_B       = ((r_state == S_LOAD) || (r_state == S_STREAM)) ? r_b : '0;

endmodule
